// File: rtl/log_stream_unit.sv
// log_stream_unit: valid/ready wrapper around the fixed-latency FP32 log core.
// FP64<->FP32 conversion, special-case bypass and a credit-guarded result FIFO.
module log_stream_unit #(
  parameter int CORE_LAT   = 28,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      core_num,
  input  logic [31:0]      core_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags,
  output logic             busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF64 = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF64 = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] QNAN32 = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] PINF32 = 64'h0000_0000_7F80_0000;
  localparam logic [63:0] NINF32 = 64'h0000_0000_FF80_0000;

  typedef struct packed {
    logic             valid;
    logic             fmt;
    logic [TAG_W-1:0] tag;
    logic             special;
    logic [63:0]      sval;
    logic [2:0]       flags;
  } sb_t;

  typedef struct packed {
    logic             fmt;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
    logic [63:0]      data;
  } ent_t;

  sb_t         s0_d, s0_q;
  logic [31:0] num_d, num_q;
  sb_t         sb_d [CORE_LAT];
  sb_t         sb_q [CORE_LAT];
  sb_t         tail;

  ent_t        mem_q [FIFO_DEPTH];
  ent_t        wr_ent, head;
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] fcnt_d, fcnt_q;
  logic [CW-1:0] cnt_d, cnt_q;

  logic accept, pop, wr_en;

  logic        sgn, is_nan, is_inf, is_zero, hi, lo;
  logic [7:0]  e32;
  logic [22:0] m32;
  logic [10:0] e64;
  logic [51:0] m64;
  logic [31:0] nrm;

  logic [7:0]  le;
  logic [63:0] widened;

  function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign in_ready = !srstn && (cnt_q < CW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign busy     = (cnt_q != '0);
  assign core_num = s0_q.valid ? num_q : 32'h0;

  always_comb begin
    sgn = 1'b0; is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
    hi  = 1'b0; lo = 1'b0; nrm = '0;
    e32 = in_data[30:23];
    m32 = in_data[22:0];
    e64 = in_data[62:52];
    m64 = in_data[51:0];
    if (in_fmt) begin
      sgn     = in_data[31];
      is_nan  = (&e32) && (|m32);
      is_inf  = (&e32) && !(|m32);
      is_zero = !(|e32) && !(|m32);
      lo      = !(|e32);
      nrm     = in_data[31:0];
    end else begin
      sgn     = in_data[63];
      is_nan  = (&e64) && (|m64);
      is_inf  = (&e64) && !(|m64);
      is_zero = !(|e64) && !(|m64);
      hi      = (e64 >= 11'd1151);
      lo      = (e64 <= 11'd896);
      nrm     = {1'b0, 8'(e64 - 11'd896), m64[51:29]};
    end
  end

  // NaN is tested before sign so a negative NaN still reads as plain NaN
  always_comb begin
    s0_d       = '0;
    num_d      = '0;
    s0_d.valid = accept;
    s0_d.fmt   = in_fmt;
    s0_d.tag   = in_tag;
    if (is_nan) begin
      s0_d.special = 1'b1;
      s0_d.sval    = in_fmt ? QNAN32 : QNAN64;
    end else if (is_zero) begin
      s0_d.special = 1'b1;
      s0_d.sval    = in_fmt ? NINF32 : NINF64;
      s0_d.flags   = 3'b010;
    end else if (sgn) begin
      s0_d.special = 1'b1;
      s0_d.sval    = in_fmt ? QNAN32 : QNAN64;
      s0_d.flags   = 3'b100;
    end else if (is_inf) begin
      s0_d.special = 1'b1;
      s0_d.sval    = in_fmt ? PINF32 : PINF64;
    end else if (hi) begin
      num_d      = 32'h7F7F_FFFF;
      s0_d.flags = 3'b001;
    end else if (lo) begin
      num_d      = 32'h0080_0000;
      s0_d.flags = 3'b001;
    end else begin
      num_d = nrm;
    end
  end

  always_comb begin
    sb_d[0] = s0_q;
    for (int i = 1; i < CORE_LAT; i++) sb_d[i] = sb_q[i-1];
  end

  assign tail  = sb_q[CORE_LAT-1];
  assign wr_en = tail.valid;
  assign le    = core_log[30:23];

  always_comb begin
    if (le == 8'd0)
      widened = {core_log[31], 63'b0};
    else if (le == 8'hFF)
      widened = {core_log[31], 11'h7FF, core_log[22:0], 29'b0};
    else
      widened = {core_log[31], {3'b0, le} + 11'd896, core_log[22:0], 29'b0};
  end

  always_comb begin
    wr_ent       = '0;
    wr_ent.fmt   = tail.fmt;
    wr_ent.tag   = tail.tag;
    wr_ent.flags = tail.flags;
    if (tail.special)  wr_ent.data = tail.sval;
    else if (tail.fmt) wr_ent.data = {32'h0, core_log};
    else               wr_ent.data = widened;
  end

  assign out_valid = (fcnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head.data  : '0;
  assign out_fmt   = out_valid ? head.fmt   : 1'b0;
  assign out_tag   = out_valid ? head.tag   : '0;
  assign out_flags = out_valid ? head.flags : '0;

  always_comb begin
    wr_ptr_d = wr_en ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d   = fcnt_q + CW'(wr_en) - CW'(pop);
    cnt_d    = cnt_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk or posedge srstn) begin
    if (srstn) begin
      s0_q     <= '0;
      num_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < CORE_LAT; i++) sb_q[i] <= '0;
    end else begin
      s0_q     <= s0_d;
      num_q    <= num_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < CORE_LAT; i++) sb_q[i] <= sb_d[i];
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_ent;
  end

endmodule

// File: tb/tb_log_stream_unit.sv
// tb_log_stream_unit: scoreboard bench with a behavioural log-core model.
// Random and directed requests are checked in order against a reference.
module tb_log_stream_unit;
  localparam int L  = 28;
  localparam int D  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          srstn = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_fmt = 1'b0;
  logic          out_ready = 1'b0;
  logic [63:0]   in_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid, out_fmt, busy;
  logic [31:0]   core_num;
  logic [31:0]   core_log = '0;
  logic [63:0]   out_data;
  logic [TW-1:0] out_tag;
  logic [2:0]    out_flags;

  always #5 clk = ~clk;

  log_stream_unit #(.CORE_LAT(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .srstn(srstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_fmt(in_fmt), .in_tag(in_tag),
    .core_num(core_num), .core_log(core_log),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_fmt(out_fmt),
    .out_tag(out_tag), .out_flags(out_flags),
    .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] core_f(logic [31:0] x);
    if (x == 32'h4000_0000) return 32'h3F31_7218;
    return {x[7:0], x[31:8]} ^ 32'h2468_ACE1;
  endfunction

  // core model: whatever was on core_num L cycles ago, garbage for idle slots
  logic [31:0] sh [L+1];
  initial for (int i = 0; i <= L; i++) sh[i] = '0;
  always @(negedge clk) begin
    for (int i = L; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = core_num;
    core_log = (sh[L] == 32'h0) ? $urandom : core_f(sh[L]);
  end

  typedef struct packed {
    logic        sp;
    logic [63:0] sv;
    logic [2:0]  fl;
    logic [31:0] num;
  } cls_t;

  typedef struct {
    logic [63:0]   data;
    logic          fmt;
    logic [TW-1:0] tag;
    logic [2:0]    flags;
    int            acc;
    bit            chk_lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   seen = 0;

  function automatic cls_t classify(logic [63:0] d, logic f);
    cls_t c; int ex; logic s; logic [51:0] fr; bit nan, inf, zero;
    c = '0;
    if (f) begin
      s = d[31]; ex = int'(d[30:23]); fr = {d[22:0], 29'b0};
      nan = (ex == 255) && (fr != 0); inf = (ex == 255) && (fr == 0);
      zero = (ex == 0) && (fr == 0);
      ex = (ex == 0) ? -1000 : ex - 127;
    end else begin
      s = d[63]; ex = int'(d[62:52]); fr = d[51:0];
      nan = (ex == 2047) && (fr != 0); inf = (ex == 2047) && (fr == 0);
      zero = (ex == 0) && (fr == 0);
      ex = (ex == 0) ? -2000 : ex - 1023;
    end
    if (nan) begin
      c.sp = 1; c.sv = f ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
    end else if (zero) begin
      c.sp = 1; c.sv = f ? 64'hFF80_0000 : 64'hFFF0_0000_0000_0000;
      c.fl = 3'b010;
    end else if (s) begin
      c.sp = 1; c.sv = f ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
      c.fl = 3'b100;
    end else if (inf) begin
      c.sp = 1; c.sv = f ? 64'h7F80_0000 : 64'h7FF0_0000_0000_0000;
    end else if (ex > 127) begin
      c.num = 32'h7F7F_FFFF; c.fl = 3'b001;
    end else if (ex < -126) begin
      c.num = 32'h0080_0000; c.fl = 3'b001;
    end else begin
      c.num = {1'b0, 8'(ex + 127), fr[51:29]};
    end
    return c;
  endfunction

  function automatic logic [63:0] widen(logic [31:0] x);
    int ex;
    ex = int'(x[30:23]);
    if (ex == 0) return {x[31], 63'b0};
    if (ex == 255) return {x[31], 11'h7FF, x[22:0], 29'b0};
    return {x[31], 11'(ex - 127 + 1023), x[22:0], 29'b0};
  endfunction

  function automatic logic [63:0] rand_op(logic f);
    logic [63:0] r; logic s; int k;
    logic [7:0] e8; logic [10:0] e11;
    r = {$urandom, $urandom};
    s = ($urandom_range(0, 4) == 0);
    k = $urandom_range(0, 13);
    if (f) begin
      case (k)
        0: begin e8 = 8'd0; r[22:0] = '0; end
        1: begin e8 = 8'd0; r[0] = 1'b1; end
        2: begin e8 = 8'hFF; r[22:0] = '0; end
        3: begin e8 = 8'hFF; r[0] = 1'b1; end
        4: e8 = 8'd1;
        5: e8 = 8'd254;
        default: e8 = 8'($urandom_range(1, 254));
      endcase
      r[31:23] = {s, e8};
    end else begin
      case (k)
        0: begin e11 = 11'd0; r[51:0] = '0; end
        1: begin e11 = 11'd0; r[0] = 1'b1; end
        2: begin e11 = 11'h7FF; r[51:0] = '0; end
        3: begin e11 = 11'h7FF; r[0] = 1'b1; end
        4: e11 = 11'd896;
        5: e11 = 11'd1151;
        6: e11 = 11'd897;
        7: e11 = 11'd1150;
        8: e11 = 11'($urandom_range(1151, 2046));
        9: e11 = 11'($urandom_range(1, 896));
        default: e11 = 11'($urandom_range(897, 1150));
      endcase
      r[63:52] = {s, e11};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic try_send(input logic [63:0] d, input logic f, input logic [TW-1:0] t,
                          input bit cn, input bit cl, output bit ok);
    cls_t c; exp_t e;
    in_valid = 1'b1; in_data = d; in_fmt = f; in_tag = t;
    ok = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) begin
      c = classify(d, f);
      if (c.sp)   e.data = c.sv;
      else if (f) e.data = {32'h0, core_f(c.num)};
      else        e.data = widen(core_f(c.num));
      e.fmt = f; e.tag = t; e.flags = c.fl;
      e.acc = cyc - 1; e.chk_lat = cl;
      q.push_back(e);
      if (cn) chk("core_num", {32'h0, core_num}, {32'h0, c.num});
    end
  endtask

  task automatic send(input logic [63:0] d, input logic f, input logic [TW-1:0] t,
                      input bit cn, input bit cl, input bit rr);
    bit ok;
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (rr) out_ready = ($urandom_range(0, 3) != 0);
      try_send(d, f, t, cn, cl, ok);
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results pending, want 0", q.size());
    end
  endtask

  task automatic monitor();
    exp_t h;
    forever begin
      @(negedge clk);
      #1;
      if (!srstn && out_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL spurious_out: got tag %0d data %h want no result", out_tag, out_data);
        end else begin
          h = q[0];
          if (h.chk_lat && !seen) chk("latency", 64'(cyc - h.acc), 64'(L + 2));
          seen = 1;
          if (out_ready) begin
            chk("out_data", out_data, h.data);
            chk("out_fmt", {63'b0, out_fmt}, {63'b0, h.fmt});
            chk("out_tag", 64'(out_tag), 64'(h.tag));
            chk("out_flags", 64'(out_flags), 64'(h.flags));
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  endtask

  initial begin
    int acc; bit ok; logic fm;
    fork
      monitor();
    join_none

    srstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_core_num", {32'h0, core_num}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    srstn = 1'b0;
    #1 chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

    @(negedge clk);
    out_ready = 1'b1;
    send(64'h4000_0000_0000_0000, 1'b0, 4'd3, 1, 1, 0);
    drain();
    send(64'h0000_0000_4000_0000, 1'b1, 4'd5, 1, 1, 0);
    drain();
    send(64'h0000_0000_0000_0000, 1'b0, 4'd1, 0, 1, 0);
    send(64'hBFF0_0000_0000_0000, 1'b0, 4'd2, 0, 0, 0);
    send(64'h7FF0_0000_0000_0000, 1'b0, 4'd4, 0, 0, 0);
    drain();
    send(64'h7FE0_0000_0000_0000, 1'b0, 4'd6, 1, 0, 0);
    send(64'h0000_0000_0000_0001, 1'b0, 4'd7, 1, 0, 0);
    drain();

    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < D + L + 10; i++) begin
      fm = 1'($urandom_range(0, 1));
      try_send(rand_op(fm), fm, TW'(acc), 0, 0, ok);
      if (ok) acc++;
    end
    chk("bp_accepts", 64'(acc), 64'(D));
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_busy", {63'b0, busy}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_pop", {63'b0, in_ready}, 64'd1);
    drain();

    for (int i = 0; i < 10; i++) begin
      fm = 1'($urandom_range(0, 1));
      send(rand_op(fm), fm, TW'(i), 0, 0, 0);
    end
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    #2 srstn = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("mid_rst_core_num", {32'h0, core_num}, 64'd0);
    q.delete();
    seen = 0;
    repeat (3) @(negedge clk);
    srstn = 1'b0;
    repeat (L + 10) @(negedge clk);
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    send(64'h4000_0000_0000_0000, 1'b0, 4'd9, 1, 1, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      fm = 1'($urandom_range(0, 1));
      send(rand_op(fm), fm, TW'($urandom), 0, 0, 1);
    end
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/log_stream_unit.md
Name: log_stream_unit

Overview:
- Streaming, parametrised front/back end for the fixed-latency FP32 log core.
- Adds a valid/ready handshake with per-request tag and format, and converts FP64 to FP32 on the way in and FP32 to FP64 on the way out.
- Handles IEEE special cases by bypassing the core, and absorbs back-pressure with a credit-guarded result FIFO, because the core cannot stall.
- Replaces the fixed enable/counter valid scheme in the math subsystem.

Parameters:
CORE_LAT, 28, cycles from core_num presented to matching core_log (≥1)
FIFO_DEPTH, 32, result FIFO entries; also the cap on in-flight requests (≥1)
TAG_W, 4, width of the request tag carried alongside the data

Ports:
clk  in  1  clock, all logic on rising edge
srstn  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_data  in  64  operand; FP64, or FP32 in [31:0] when in_fmt=1
in_fmt  in  1  0=FP64, 1=FP32
in_tag  in  TAG_W  request tag, returned unchanged
core_num  out  32  FP32 operand to log core
core_log  in  32  FP32 core result, CORE_LAT cycles after core_num
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  64  FP64 result, or {32'h0, FP32} when out_fmt=1
out_fmt  out  1  echo of in_fmt
out_tag  out  TAG_W  echo of in_tag
out_flags  out  3  [2]=invalid, [1]=div-by-zero, [0]=range-clamped
busy  out  1  any request in flight or in the FIFO

Behaviour:
- Reset (srstn=1, any time): in_ready=0, out_valid=0, busy=0, core_num=0, out_data/out_tag/out_flags=0. The FIFO and sideband pipe are emptied. In-flight requests are discarded, and their core results are ignored. in_ready=1 in the first cycle after deassertion.
- Occupancy count = in-flight + FIFO entries. in_ready = (count < FIFO_DEPTH). On accept, count +1; on pop, count −1; on simultaneous accept and pop, count is unchanged.
- Stage 0 (accept edge): register operand, fmt, tag, classify result, flags.
- Core path: core_num is driven from the stage-0 register during the cycle after accept (cycle t+1). It is 0 when no request is valid.
- Sideband shift register: CORE_LAT stages of {valid, fmt, tag, special, special_value, flags}, aligned with core_log.
- At cycle t+1+CORE_LAT, the result is written to the FIFO: special_value if special, else the converted core_log. Earliest out_valid is cycle t+CORE_LAT+2.
- Throughput: one request per cycle when out_ready is held high and FIFO_DEPTH ≥ CORE_LAT+2.
- Order: strictly in-order; results are never dropped or duplicated.
- FP64→FP32 conversion: e32 = e64 − 896 and mantissa = m64[51:29], truncated with no rounding.
  - If e32 > 254 for a finite input: clamp to 0x7F7FFFFF and set flag[0].
  - If e32 < 1 (including FP64 subnormals): clamp to 0x00800000 and set flag[0].
  - FP32-mode subnormals clamp the same way.
- Special cases (core bypassed, sign taken from the input):
  - ±0 → −inf, flag[1].
  - Negative nonzero, including −inf → qNaN, flag[2].
  - NaN → qNaN.
  - +inf → +inf.
  - FP64 encodings: −inf 0xFFF0000000000000, +inf 0x7FF0000000000000, qNaN 0x7FF8000000000000.
  - FP32 encodings: 0xFF800000, 0x7F800000, 0x7FC00000.
- FP32→FP64 conversion (out_fmt=0):
  - Exponent 0 → ±0.
  - Exponent 255 → exponent 2047 with the mantissa zero-padded.
  - Otherwise exponent +896 and mantissa {m32, 29'b0}.
- FIFO output is first-word-fall-through. out_data, out_fmt, out_tag and out_flags hold stable while out_valid && !out_ready.
- busy = (count ≠ 0).
- in_valid while in_ready=0: no accept, and the input need not be held stable.

Test Plan:
- Bench core model returns 0x3F317218 for 0x40000000. Input in_data=0x4000000000000000, fmt=0, tag=3, out_ready=1. Required: core_num=0x40000000 at t+1; out_valid at t+CORE_LAT+2; out_data=0x3FE62E4300000000, tag=3, flags=0.
- Same operand in FP32 mode (in_data=0x0000000040000000, fmt=1). Required: out_data=0x000000003F317218, out_fmt=1.
- Special cases:
  - 0x0 → 0xFFF0000000000000, flags=010.
  - 0xBFF0000000000000 → 0x7FF8000000000000, flags=100.
  - 0x7FF0000000000000 → 0x7FF0000000000000, flags=000.
  - In all three, core_log is ignored (bench drives garbage).
- Range clamp: 0x7FE0000000000000 gives core_num=0x7F7FFFFF and flags=001. 0x0000000000000001 gives core_num=0x00800000 and flags=001.
- Back-pressure: out_ready=0, in_valid=1 continuously with tags 0,1,2,… Required: exactly FIFO_DEPTH accepts, then in_ready=0 and busy=1. Then with out_ready=1, all results emerge in tag order with none lost, and in_ready returns 1 on the first pop cycle.
- Reset mid-stream: assert srstn with 10 requests in flight. Required: out_valid=0 and busy=0 asynchronously, and no stale results after release. A new request then completes with correct latency and data.
